vector_sequencer: RTL and testbench



---
 rtl/vector_pkg.sv | 27 ++
 rtl/vector_sequencer_if.sv | 28 ++
 rtl/seq_watchdog.sv | 29 ++
 rtl/vector_sequencer.sv | 135 +++++++++++++
 tb/tb_vector_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector display sequencer: FSM encoding and
// display-list entry field layout.
package vector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_LAUNCH,
        ST_WAIT_START,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

    localparam int ENTRY_W  = 33;
    localparam int LAST_BIT = 32;
    localparam int STAX_MSB = 31;
    localparam int STAX_LSB = 24;
    localparam int STAY_MSB = 23;
    localparam int STAY_LSB = 16;
    localparam int ENDX_MSB = 15;
    localparam int ENDX_LSB = 8;
    localparam int ENDY_MSB = 7;
    localparam int ENDY_LSB = 0;

endpackage

// File: rtl/vector_sequencer_if.sv
// Display-list read port and linedraw launch/coordinate bundle.
interface vector_sequencer_if
    import vector_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [ENTRY_W-1:0] mem_data;
    logic               ld_go;
    logic [7:0]         ld_stax;
    logic [7:0]         ld_stay;
    logic [7:0]         ld_endx;
    logic [7:0]         ld_endy;
    logic               ld_busy;

    modport master (
        output mem_addr, mem_rd, ld_go, ld_stax, ld_stay, ld_endx, ld_endy,
        input  mem_data, ld_busy
    );

    modport slave (
        input  mem_addr, mem_rd, ld_go, ld_stax, ld_stay, ld_endx, ld_endy,
        output mem_data, ld_busy
    );

endinterface

// File: rtl/seq_watchdog.sv
// Per-segment draw watchdog: clearable up-counter that stops and flags
// expiry once it reaches TIMEOUT.
module seq_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// Frame controller: walks the display list and launches one linedraw run per
// segment, holding coordinates stable and blanking the beam between segments.
module vector_sequencer
    import vector_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic              blank,
    output logic [ADDR_W:0]   seg_count,
    vector_sequencer_if.master bus
);

    localparam logic [ADDR_W:0] LIST_SIZE = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   seg_count_q;
    logic              last_q;
    logic [7:0]        stax_q, stay_q, endx_q, endy_q;
    logic              timeout_err_q, overrun_err_q;
    logic              wd_expired;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_LAUNCH),
        .en      ((state_q == ST_WAIT_START) || (state_q == ST_DRAW)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (frame_start) state_d = ST_FETCH;
            ST_FETCH:      state_d = ST_WAIT_DATA;
            ST_WAIT_DATA:  state_d = ST_LAUNCH;
            ST_LAUNCH:     state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (wd_expired)       state_d = ST_DONE;
                else if (bus.ld_busy) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (wd_expired)        state_d = ST_DONE;
                else if (!bus.ld_busy) state_d = ST_NEXT;
            end
            // Every segment that reaches NEXT was read exactly once, so the
            // completed-segment count doubles as the read count here.
            ST_NEXT: begin
                if (last_q || (seg_count_q == LIST_SIZE)) state_d = ST_DONE;
                else                                      state_d = ST_FETCH;
            end
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            seg_count_q   <= '0;
            last_q        <= 1'b0;
            stax_q        <= '0;
            stay_q        <= '0;
            endx_q        <= '0;
            endy_q        <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        addr_q        <= base_addr;
                        seg_count_q   <= '0;
                        timeout_err_q <= 1'b0;
                        overrun_err_q <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    last_q <= bus.mem_data[LAST_BIT];
                    stax_q <= bus.mem_data[STAX_MSB:STAX_LSB];
                    stay_q <= bus.mem_data[STAY_MSB:STAY_LSB];
                    endx_q <= bus.mem_data[ENDX_MSB:ENDX_LSB];
                    endy_q <= bus.mem_data[ENDY_MSB:ENDY_LSB];
                end
                ST_WAIT_START: begin
                    if (wd_expired) timeout_err_q <= 1'b1;
                end
                ST_DRAW: begin
                    if (wd_expired)        timeout_err_q <= 1'b1;
                    else if (!bus.ld_busy) seg_count_q   <= seg_count_q + (ADDR_W+1)'(1);
                end
                ST_NEXT: begin
                    if (!last_q) begin
                        if (seg_count_q == LIST_SIZE) overrun_err_q <= 1'b1;
                        else                          addr_q        <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_busy   = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);
    assign blank        = (state_q != ST_DRAW);
    assign timeout_err  = timeout_err_q;
    assign overrun_err  = overrun_err_q;
    assign seg_count    = seg_count_q;

    assign bus.mem_addr = addr_q;
    assign bus.mem_rd   = (state_q == ST_FETCH);
    assign bus.ld_go    = (state_q == ST_LAUNCH);
    assign bus.ld_stax  = stax_q;
    assign bus.ld_stay  = stay_q;
    assign bus.ld_endx  = endx_q;
    assign bus.ld_endy  = endy_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: a wide-list instance for normal,
// timeout and reset cases, and a 4-entry instance for list overrun.
module tb_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DUT A: 256-entry list
    logic       fs_a = 1'b0;
    logic [7:0] base_a = '0;
    logic       fbusy_a, fdone_a, terr_a, oerr_a, blank_a;
    logic [8:0] segc_a;
    vector_sequencer_if #(.ADDR_W(8)) bus_a ();

    vector_sequencer #(.ADDR_W(8), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .base_addr(base_a),
        .frame_busy(fbusy_a), .frame_done(fdone_a), .timeout_err(terr_a),
        .overrun_err(oerr_a), .blank(blank_a), .seg_count(segc_a), .bus(bus_a)
    );

    // DUT B: 4-entry list
    logic       fs_b = 1'b0;
    logic [1:0] base_b = '0;
    logic       fbusy_b, fdone_b, terr_b, oerr_b, blank_b;
    logic [2:0] segc_b;
    vector_sequencer_if #(.ADDR_W(2)) bus_b ();

    vector_sequencer #(.ADDR_W(2), .TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .base_addr(base_b),
        .frame_busy(fbusy_b), .frame_done(fdone_b), .timeout_err(terr_b),
        .overrun_err(oerr_b), .blank(blank_b), .seg_count(segc_b), .bus(bus_b)
    );

    // Display-list RAMs with one-cycle read latency
    logic [32:0] mem_a [0:255];
    logic [32:0] mem_b [0:3];
    logic [32:0] rdata_a = '0, rdata_b = '0;
    always @(posedge clk) begin
        if (bus_a.mem_rd) rdata_a <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_rd) rdata_b <= mem_b[bus_b.mem_addr];
    end
    assign bus_a.mem_data = rdata_a;
    assign bus_b.mem_data = rdata_b;

    // Linedraw models: no reset, busy for draw_len cycles after an accepted go
    int draw_len_a = 5, draw_len_b = 2;
    bit busy_en_a = 1'b1;
    int bcnt_a = 0, bcnt_b = 0;
    always @(posedge clk) begin
        if (bcnt_a > 0)                      bcnt_a <= bcnt_a - 1;
        else if (bus_a.ld_go && busy_en_a)   bcnt_a <= draw_len_a;
        if (bcnt_b > 0)                      bcnt_b <= bcnt_b - 1;
        else if (bus_b.ld_go)                bcnt_b <= draw_len_b;
    end
    assign bus_a.ld_busy = (bcnt_a != 0);
    assign bus_b.ld_busy = (bcnt_b != 0);

    // Event monitors (monotonic; the bench compares deltas)
    int go_a = 0, gob_a = 0, blo_a = 0, rd_a = 0, go_b = 0, rd_b = 0;
    logic [7:0] alog_a [0:255];
    logic [1:0] alog_b [0:255];
    always @(posedge clk) begin
        if (bus_a.ld_go) go_a <= go_a + 1;
        if (bus_a.ld_go && bus_a.ld_busy) gob_a <= gob_a + 1;
        if (!blank_a) blo_a <= blo_a + 1;
        if (bus_a.mem_rd) begin
            alog_a[rd_a[7:0]] <= bus_a.mem_addr;
            rd_a <= rd_a + 1;
        end
        if (bus_b.ld_go) go_b <= go_b + 1;
        if (bus_b.mem_rd) begin
            alog_b[rd_b[7:0]] <= bus_b.mem_addr;
            rd_b <= rd_b + 1;
        end
    end

    task automatic start_frame(input bit sel_b, input logic [7:0] base);
        if (sel_b) begin fs_b = 1'b1; base_b = base[1:0]; end
        else       begin fs_a = 1'b1; base_a = base;      end
        tick();
        fs_a = 1'b0;
        fs_b = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit sel_b, input int limit, input int exp_ticks);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < limit) begin
            tick();
            n++;
            if (sel_b ? fdone_b : fdone_a) seen = 1'b1;
        end
        check_val(tag, n, exp_ticks);
    endtask

    int go0, gob0, blo0, rd0;

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = '0;
        for (int i = 0; i < 4; i++)   mem_b[i] = {1'b0, 8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
        mem_a[8'h00] = {1'b1, 8'd10, 8'd10, 8'd20, 8'd15};
        mem_a[8'h40] = {1'b0, 8'd1,  8'd2,  8'd3,  8'd4};
        mem_a[8'h41] = {1'b0, 8'd5,  8'd6,  8'd7,  8'd8};
        mem_a[8'h42] = {1'b1, 8'd9,  8'd9,  8'd9,  8'd9};

        // Reset state
        tick();
        tick();
        check_val("rst_blank", blank_a, 1'b1);
        check_val("rst_busy", fbusy_a, 1'b0);
        check_val("rst_done", fdone_a, 1'b0);
        check_val("rst_go", bus_a.ld_go, 1'b0);
        check_val("rst_rd", bus_a.mem_rd, 1'b0);
        check_val("rst_segc", segc_a, 0);
        check_val("rst_errs", {terr_a, oerr_a}, 0);
        check_val("rst_stax", bus_a.ld_stax, 0);
        check_val("rst_blank_b", blank_b, 1'b1);
        rst_n = 1'b1;
        tick();

        // Single segment (10,10)->(20,15)
        draw_len_a = 5;
        go0 = go_a; blo0 = blo_a;
        start_frame(1'b0, 8'h00);
        check_val("t1_c1_rd", bus_a.mem_rd, 1'b1);
        check_val("t1_c1_addr", bus_a.mem_addr, 8'h00);
        check_val("t1_c1_busy", fbusy_a, 1'b1);
        tick();
        check_val("t1_c2_go", bus_a.ld_go, 1'b0);
        tick();
        check_val("t1_c3_go", bus_a.ld_go, 1'b1);
        check_val("t1_coords", {bus_a.ld_stax, bus_a.ld_stay, bus_a.ld_endx, bus_a.ld_endy},
                  {8'd10, 8'd10, 8'd20, 8'd15});
        tick();
        check_val("t1_c4_go", bus_a.ld_go, 1'b0);
        check_val("t1_c4_blank", blank_a, 1'b1);
        tick();
        check_val("t1_c5_blank", blank_a, 1'b0);
        wait_done("t1_done_cycle", 1'b0, 60, 6);
        check_val("t1_segc", segc_a, 1);
        check_val("t1_errs", {terr_a, oerr_a}, 0);
        check_val("t1_gos", go_a - go0, 1);
        check_val("t1_unblank_cycles", blo_a - blo0, 5);
        tick();
        check_val("t1_done_pulse", fdone_a, 1'b0);
        check_val("t1_idle", fbusy_a, 1'b0);

        // Three segments at 0x40
        draw_len_a = 3;
        go0 = go_a; gob0 = gob_a; rd0 = rd_a;
        start_frame(1'b0, 8'h40);
        wait_done("t2_done_cycle", 1'b0, 100, 24);
        check_val("t2_segc", segc_a, 3);
        check_val("t2_reads", rd_a - rd0, 3);
        check_val("t2_addr0", alog_a[rd0[7:0]], 8'h40);
        check_val("t2_addr1", alog_a[8'(rd0 + 1)], 8'h41);
        check_val("t2_addr2", alog_a[8'(rd0 + 2)], 8'h42);
        check_val("t2_gos", go_a - go0, 3);
        check_val("t2_go_while_busy", gob_a - gob0, 0);
        check_val("t2_last_coords", {bus_a.ld_stax, bus_a.ld_endy}, {8'd9, 8'd9});
        tick();

        // Watchdog: linedraw never goes busy
        busy_en_a = 1'b0;
        go0 = go_a; blo0 = blo_a;
        start_frame(1'b0, 8'h00);
        wait_done("t3_done_cycle", 1'b0, 60, 20);
        check_val("t3_timeout", terr_a, 1'b1);
        check_val("t3_segc", segc_a, 0);
        check_val("t3_gos", go_a - go0, 1);
        check_val("t3_unblank_cycles", blo_a - blo0, 0);
        tick();
        check_val("t3_sticky", terr_a, 1'b1);
        busy_en_a = 1'b1;
        start_frame(1'b0, 8'h00);
        check_val("t3_clear", terr_a, 1'b0);
        wait_done("t3_rerun_cycle", 1'b0, 60, 8);
        check_val("t3_rerun_err", terr_a, 1'b0);
        tick();

        // Overrun on the 4-entry list starting at 3
        go0 = go_b; rd0 = rd_b;
        start_frame(1'b1, 8'h03);
        wait_done("t4_done_cycle", 1'b1, 100, 28);
        check_val("t4_overrun", oerr_b, 1'b1);
        check_val("t4_segc", segc_b, 4);
        check_val("t4_reads", rd_b - rd0, 4);
        check_val("t4_addrs", {alog_b[rd0[7:0]], alog_b[8'(rd0 + 1)], alog_b[8'(rd0 + 2)], alog_b[8'(rd0 + 3)]},
                  {2'd3, 2'd0, 2'd1, 2'd2});
        check_val("t4_gos", go_b - go0, 4);
        check_val("t4_timeout_b", terr_b, 1'b0);
        tick();
        start_frame(1'b1, 8'h00);
        check_val("t4_clear", oerr_b, 1'b0);
        wait_done("t4_rerun_cycle", 1'b1, 100, 28);
        check_val("t4_rerun_overrun", oerr_b, 1'b1);
        tick();

        // frame_start during DRAW is ignored
        draw_len_a = 8;
        go0 = go_a; rd0 = rd_a;
        start_frame(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        fs_a = 1'b1;
        base_a = 8'h40;
        tick();
        fs_a = 1'b0;
        base_a = 8'h00;
        check_val("t5_still_draw", blank_a, 1'b0);
        wait_done("t5_done_cycle", 1'b0, 60, 7);
        check_val("t5_segc", segc_a, 1);
        check_val("t5_gos", go_a - go0, 1);
        check_val("t5_reads", rd_a - rd0, 1);
        check_val("t5_addr", alog_a[rd0[7:0]], 8'h00);
        tick();

        // Asynchronous reset mid-DRAW
        draw_len_a = 20;
        start_frame(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick();
        check_val("t6_in_draw", blank_a, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_blank", blank_a, 1'b1);
        check_val("t6_rst_busy", fbusy_a, 1'b0);
        check_val("t6_rst_go", bus_a.ld_go, 1'b0);
        check_val("t6_rst_rd", bus_a.mem_rd, 1'b0);
        check_val("t6_rst_segc", segc_a, 0);
        check_val("t6_rst_coords", {bus_a.ld_stax, bus_a.ld_stay, bus_a.ld_endx, bus_a.ld_endy}, 0);
        tick();
        rst_n = 1'b1;
        begin
            int n = 0;
            while (bus_a.ld_busy && n < 40) begin tick(); n++; end
            check_val("t6_engine_idle", bus_a.ld_busy, 1'b0);
        end
        check_val("t6_stays_idle", fbusy_a, 1'b0);
        draw_len_a = 4;
        go0 = go_a;
        start_frame(1'b0, 8'h00);
        wait_done("t6_done_cycle", 1'b0, 60, 9);
        check_val("t6_segc", segc_a, 1);
        check_val("t6_gos", go_a - go0, 1);
        check_val("t6_coords", {bus_a.ld_stax, bus_a.ld_stay, bus_a.ld_endx, bus_a.ld_endy},
                  {8'd10, 8'd10, 8'd20, 8'd15});
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
